// File: rtl/pong_ball_engine.sv
// Ball dynamics for pong: single-clock step prescaler, wall/paddle/goal handling,
// scores, serve/play/goal/over sequencing and sound event generation.
module pong_ball_engine #(
  parameter int WIDTH_SCREEN  = 640,
  parameter int HEIGHT_SCREEN = 480,
  parameter int SIZE_BALL     = 10,
  parameter int SEPARATOR     = 20,
  parameter int WIDTH_PLAYER  = 12,
  parameter int HEIGHT_PLAYER = 90,
  parameter int POS_W         = 10,
  parameter int VX_INIT       = 1,
  parameter int VY_INIT       = 2,
  parameter int DELAY_INIT    = 16,
  parameter int DELAY_MIN     = 4,
  parameter int DELAY_MAX     = 24,
  parameter int SERVE_STEPS   = 64,
  parameter int WIN_SCORE     = 9,
  parameter int SOUND_LEN     = 1 << 20
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [POS_W-1:0] pos_player1,
  input  logic [POS_W-1:0] pos_player2,
  input  logic             inc_vel,
  input  logic             dec_vel,
  output logic [POS_W-1:0] x_ball,
  output logic [POS_W-1:0] y_ball,
  output logic [3:0]       score1,
  output logic [3:0]       score2,
  output logic             game_over,
  output logic             sound_strobe,
  output logic [1:0]       code_sound,
  output logic             mute
);
  localparam int SW  = POS_W + 2;
  localparam int SCW = $clog2(SERVE_STEPS + 1);
  localparam int MW  = $clog2(SOUND_LEN + 1);

  localparam logic [POS_W-1:0] X_CTR = POS_W'((WIDTH_SCREEN - SIZE_BALL) / 2);
  localparam logic [POS_W-1:0] Y_CTR = POS_W'((HEIGHT_SCREEN - SIZE_BALL) / 2);
  localparam logic signed [SW-1:0] ZERO  = '0;
  localparam logic signed [SW-1:0] X_MAX = SW'(WIDTH_SCREEN - SIZE_BALL);
  localparam logic signed [SW-1:0] Y_MAX = SW'(HEIGHT_SCREEN - SIZE_BALL);
  localparam logic signed [SW-1:0] X_PL  = SW'(SEPARATOR + WIDTH_PLAYER);
  localparam logic signed [SW-1:0] X_PR  = SW'(WIDTH_SCREEN - SEPARATOR - WIDTH_PLAYER - SIZE_BALL);
  localparam logic signed [SW-1:0] BALL  = SW'(SIZE_BALL);
  localparam logic signed [SW-1:0] PH    = SW'(HEIGHT_PLAYER);
  localparam logic signed [SW-1:0] VX    = SW'(VX_INIT);
  localparam logic signed [SW-1:0] VY    = SW'(VY_INIT);
  localparam logic [4:0] D_INIT = 5'(DELAY_INIT);
  localparam logic [4:0] D_MIN  = 5'(DELAY_MIN);
  localparam logic [4:0] D_MAX  = 5'(DELAY_MAX);

  typedef enum logic [1:0] {SERVE, PLAY, GOAL, OVER} state_t;
  state_t state, state_nx;

  logic [31:0]          presc, mask;
  logic                 step;
  logic [4:0]           delay;
  logic                 inc_q, dec_q, inc_rise, dec_rise;
  logic                 vx_neg, vy_neg, vx_neg_nx, vy_neg_nx;
  logic [POS_W-1:0]     x_nx, y_nx;
  logic [3:0]           s1_nx, s2_nx;
  logic [SCW-1:0]       serve_cnt, serve_nx;
  logic                 ev;
  logic [1:0]           code_nx;
  logic [MW-1:0]        mute_cnt;
  logic signed [SW-1:0] xn, yn, p1, p2;
  logic                 hit_l, hit_r;

  // A step fires whenever the low `delay` bits of the free-running counter are all ones.
  assign mask     = (32'd1 << delay) - 32'd1;
  assign step     = (presc & mask) == mask;
  assign inc_rise = inc_vel & ~inc_q;
  assign dec_rise = dec_vel & ~dec_q;

  assign xn = $signed({2'b00, x_ball}) + (vx_neg ? -VX : VX);
  assign yn = $signed({2'b00, y_ball}) + (vy_neg ? -VY : VY);
  assign p1 = {2'b00, pos_player1};
  assign p2 = {2'b00, pos_player2};
  assign hit_l = vx_neg  && (xn <= X_PL) && (yn + BALL > p1) && (yn < p1 + PH);
  assign hit_r = !vx_neg && (xn >= X_PR) && (yn + BALL > p2) && (yn < p2 + PH);

  always_comb begin
    state_nx  = state;
    x_nx      = x_ball;
    y_nx      = y_ball;
    vx_neg_nx = vx_neg;
    vy_neg_nx = vy_neg;
    s1_nx     = score1;
    s2_nx     = score2;
    serve_nx  = serve_cnt;
    ev        = 1'b0;
    code_nx   = code_sound;
    if (step) begin
      unique case (state)
        SERVE: begin
          x_nx = X_CTR;
          y_nx = Y_CTR;
          serve_nx = serve_cnt + 1'b1;
          if (serve_cnt == SCW'(SERVE_STEPS - 1)) begin
            state_nx = PLAY;
            ev       = 1'b1;
            code_nx  = 2'b11;
          end
        end
        PLAY: begin
          x_nx = xn[POS_W-1:0];
          y_nx = yn[POS_W-1:0];
          if (yn <= ZERO) begin
            y_nx = '0;
            vy_neg_nx = ~vy_neg;
            ev = 1'b1;
            code_nx = 2'b10;
          end else if (yn >= Y_MAX) begin
            y_nx = Y_MAX[POS_W-1:0];
            vy_neg_nx = ~vy_neg;
            ev = 1'b1;
            code_nx = 2'b10;
          end
          // Later assignments override code_nx, giving go > pong > ping.
          if (hit_l || hit_r) begin
            x_nx = hit_l ? X_PL[POS_W-1:0] : X_PR[POS_W-1:0];
            vx_neg_nx = ~vx_neg;
            ev = 1'b1;
            code_nx = 2'b01;
          end else if (xn <= ZERO || xn >= X_MAX) begin
            // vx is left pointing at the conceding side, which is the next serve direction.
            if (xn <= ZERO) begin
              x_nx  = '0;
              s2_nx = score2 + 1'b1;
            end else begin
              x_nx  = X_MAX[POS_W-1:0];
              s1_nx = score1 + 1'b1;
            end
            ev = 1'b1;
            code_nx = 2'b11;
            state_nx = GOAL;
          end
        end
        GOAL: begin
          x_nx = X_CTR;
          y_nx = Y_CTR;
          if (score1 == 4'(WIN_SCORE) || score2 == 4'(WIN_SCORE)) state_nx = OVER;
          else begin
            state_nx = SERVE;
            serve_nx = '0;
          end
        end
        OVER: begin
          x_nx = X_CTR;
          y_nx = Y_CTR;
        end
        default: state_nx = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= SERVE;
      presc        <= '0;
      delay        <= D_INIT;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      x_ball       <= X_CTR;
      y_ball       <= Y_CTR;
      vx_neg       <= 1'b0;
      vy_neg       <= 1'b0;
      score1       <= '0;
      score2       <= '0;
      serve_cnt    <= '0;
      game_over    <= 1'b0;
      sound_strobe <= 1'b0;
      code_sound   <= 2'b00;
      mute_cnt     <= '0;
      mute         <= 1'b1;
    end else begin
      state     <= state_nx;
      presc     <= presc + 32'd1;
      inc_q     <= inc_vel;
      dec_q     <= dec_vel;
      if (inc_rise && !dec_rise && delay > D_MIN) delay <= delay - 1'b1;
      else if (dec_rise && !inc_rise && delay < D_MAX) delay <= delay + 1'b1;
      x_ball       <= x_nx;
      y_ball       <= y_nx;
      vx_neg       <= vx_neg_nx;
      vy_neg       <= vy_neg_nx;
      score1       <= s1_nx;
      score2       <= s2_nx;
      serve_cnt    <= serve_nx;
      game_over    <= (state_nx == OVER);
      sound_strobe <= ev;
      code_sound   <= code_nx;
      if (ev) begin
        mute_cnt <= MW'(SOUND_LEN - 1);
        mute     <= 1'b0;
      end else begin
        if (mute_cnt != '0) mute_cnt <= mute_cnt - 1'b1;
        mute <= (mute_cnt == '0);
      end
    end
  end
endmodule
